// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by the ID/EX stage and its ALU
// control decoder.
//   - alufn encodings driven to the EX-stage ALU
//   - RV32I major opcodes (instr[6:0])
//   - funct3 values (instr[14:12]) for arithmetic, branch, load/store and JALR
//   - alu_ctrl_t: decoded controls passed from alu_ctrl to the stage register
package riscv_pkg;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_PASS_B = 4'b0011;
  localparam logic [3:0] ALU_OR     = 4'b0100;
  localparam logic [3:0] ALU_AND    = 4'b0101;
  localparam logic [3:0] ALU_XOR    = 4'b0111;
  localparam logic [3:0] ALU_SRL    = 4'b1000;
  localparam logic [3:0] ALU_SLL    = 4'b1001;
  localparam logic [3:0] ALU_SRA    = 4'b1010;
  localparam logic [3:0] ALU_SLT    = 4'b1101;
  localparam logic [3:0] ALU_SLTU   = 4'b1111;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // OP / OP-IMM
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // BRANCH
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;
  localparam logic [2:0] F3_BLTU    = 3'b110;
  localparam logic [2:0] F3_BGEU    = 3'b111;

  // LOAD / STORE widths
  localparam logic [2:0] F3_MEM_B   = 3'b000;
  localparam logic [2:0] F3_MEM_H   = 3'b001;
  localparam logic [2:0] F3_MEM_W   = 3'b010;
  localparam logic [2:0] F3_MEM_BU  = 3'b100;
  localparam logic [2:0] F3_MEM_HU  = 3'b101;

  localparam logic [2:0] F3_JALR    = 3'b000;

  // Source of the ALU shift amount in the EX cycle.
  typedef enum logic [1:0] {
    SHAMT_ZERO = 2'd0,
    SHAMT_IMM  = 2'd1,
    SHAMT_RS2  = 2'd2
  } shamt_sel_e;

  typedef struct packed {
    logic [3:0] alufn;
    logic       a_pc;       // operand A is the PC
    logic       b_imm;      // operand B is the immediate
    shamt_sel_e shamt_sel;
    logic       writes_rd;  // instruction class writes a destination
    logic       illegal;
  } alu_ctrl_t;

  // OP / OP-IMM function by funct3; alt selects SUB / SRA.
  function automatic logic [3:0] arith_fn(input logic [2:0] funct3, input logic alt);
    logic [3:0] fn;
    case (funct3)
      F3_ADD_SUB: fn = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     fn = ALU_SLL;
      F3_SLT:     fn = ALU_SLT;
      F3_SLTU:    fn = ALU_SLTU;
      F3_XOR:     fn = ALU_XOR;
      F3_SRL_SRA: fn = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      fn = ALU_OR;
      default:    fn = ALU_AND;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/alu_ctrl.sv
// alu_ctrl: combinational decode of opcode/funct3/funct7b5 into the ALU
// function, operand selects, shift-amount source, destination-write class
// and the illegal flag.
// Ports:
//   opcode   in  7  instr[6:0]
//   funct3   in  3  instr[14:12]
//   funct7b5 in  1  instr[30]
//   ctrl     out    decoded alu_ctrl_t
module alu_ctrl
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output alu_ctrl_t  ctrl
);

  always_comb begin
    ctrl.alufn     = ALU_ADD;
    ctrl.a_pc      = 1'b0;
    ctrl.b_imm     = 1'b0;
    ctrl.shamt_sel = SHAMT_ZERO;
    ctrl.writes_rd = 1'b0;
    ctrl.illegal   = 1'b0;

    case (opcode)
      OPC_OP: begin
        ctrl.alufn     = arith_fn(funct3, funct7b5);
        ctrl.writes_rd = 1'b1;
        if (funct3 == F3_SLL || funct3 == F3_SRL_SRA)
          ctrl.shamt_sel = SHAMT_RS2;
        // funct7b5 is only meaningful for SUB and SRA
        if (funct7b5 && funct3 != F3_ADD_SUB && funct3 != F3_SRL_SRA)
          ctrl.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        // funct7b5 is an immediate bit except on shifts, so ADDI never becomes SUB
        ctrl.alufn     = arith_fn(funct3, (funct3 == F3_SRL_SRA) && funct7b5);
        ctrl.b_imm     = 1'b1;
        ctrl.writes_rd = 1'b1;
        if (funct3 == F3_SLL || funct3 == F3_SRL_SRA)
          ctrl.shamt_sel = SHAMT_IMM;
        if (funct3 == F3_SLL && funct7b5)
          ctrl.illegal = 1'b1;
      end
      OPC_LUI: begin
        ctrl.alufn     = ALU_PASS_B;
        ctrl.b_imm     = 1'b1;
        ctrl.writes_rd = 1'b1;
      end
      OPC_AUIPC, OPC_JAL: begin
        ctrl.a_pc      = 1'b1;
        ctrl.b_imm     = 1'b1;
        ctrl.writes_rd = 1'b1;
      end
      OPC_JALR: begin
        ctrl.b_imm     = 1'b1;
        ctrl.writes_rd = 1'b1;
        if (funct3 != F3_JALR)
          ctrl.illegal = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.b_imm     = 1'b1;
        ctrl.writes_rd = 1'b1;
        if (!(funct3 inside {F3_MEM_B, F3_MEM_H, F3_MEM_W, F3_MEM_BU, F3_MEM_HU}))
          ctrl.illegal = 1'b1;
      end
      OPC_STORE: begin
        ctrl.b_imm = 1'b1;
        if (!(funct3 inside {F3_MEM_B, F3_MEM_H, F3_MEM_W}))
          ctrl.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        case (funct3)
          F3_BEQ, F3_BNE, F3_BLT, F3_BGE: ctrl.alufn = ALU_SUB;
          F3_BLTU, F3_BGEU:               ctrl.alufn = ALU_SLTU;
          default:                        ctrl.illegal = 1'b1;
        endcase
      end
      default: ctrl.illegal = 1'b1;
    endcase

    // an illegal instruction must look like a harmless ADD that writes nothing
    if (ctrl.illegal) begin
      ctrl.alufn     = ALU_ADD;
      ctrl.a_pc      = 1'b0;
      ctrl.b_imm     = 1'b0;
      ctrl.shamt_sel = SHAMT_ZERO;
      ctrl.writes_rd = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_alu_stage.sv
// id_ex_alu_stage: ID/EX pipeline register with ALU control decode and
// EX-cycle operand forwarding.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   stall, flush                hold the register / load a bubble (flush wins)
//   id_*                        decoded ID-slot fields, registered on clk
//   exm_rd/regwrite/result      EX/MEM writeback (forwarding source, priority)
//   wb_rd/regwrite/result       MEM/WB writeback (forwarding source)
//   ex_valid, ex_pc, ex_rd      registered slot state
//   ex_a, ex_b, ex_shamt        ALU operands (forwarded, combinational)
//   ex_alufn, ex_regwrite       registered ALU function and destination write
//   ex_rs2_fwd                  forwarded rs2 (store data)
//   ex_illegal                  decode failed
// Build option: FORWARDING_EN -- when defined, rs1/rs2 are forwarded from
// EX/MEM then MEM/WB; otherwise registered regfile data is used and the
// hazard unit is expected to stall instead.
// Only XLEN = 32 is supported.
module id_ex_alu_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [6:0]      id_opcode,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic [4:0]      exm_rd,
  input  logic            exm_regwrite,
  input  logic [XLEN-1:0] exm_result,
  input  logic [4:0]      wb_rd,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [4:0]      ex_shamt,
  output logic [3:0]      ex_alufn,
  output logic [XLEN-1:0] ex_rs2_fwd,
  output logic [4:0]      ex_rd,
  output logic            ex_regwrite,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_illegal
);

  alu_ctrl_t id_ctrl;

  alu_ctrl u_alu_ctrl (
    .opcode   (id_opcode),
    .funct3   (id_funct3),
    .funct7b5 (id_funct7b5),
    .ctrl     (id_ctrl)
  );

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [4:0]      rd_q;
  logic [3:0]      alufn_q;
  logic            a_pc_q;
  logic            b_imm_q;
  shamt_sel_e      shamt_sel_q;
  logic            regwrite_q;
  logic            illegal_q;

  // A bubble is loaded on reset, flush, or an invalid slot that is not
  // being held; stall holds everything otherwise.
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !id_valid)) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alufn_q     <= ALU_ADD;
      a_pc_q      <= 1'b0;
      b_imm_q     <= 1'b0;
      shamt_sel_q <= SHAMT_ZERO;
      regwrite_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (!stall) begin
      valid_q     <= 1'b1;
      pc_q        <= id_pc;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      alufn_q     <= id_ctrl.alufn;
      a_pc_q      <= id_ctrl.a_pc;
      b_imm_q     <= id_ctrl.b_imm;
      shamt_sel_q <= id_ctrl.shamt_sel;
      regwrite_q  <= id_ctrl.writes_rd && (id_rd != 5'd0);
      illegal_q   <= id_ctrl.illegal;
    end
  end

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

`ifdef FORWARDING_EN
  // x0 never forwards, so a bubble (all indices zero) keeps zero operands
  function automatic logic [XLEN-1:0] forward(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] regval,
    input logic [4:0]      m_rd,
    input logic            m_we,
    input logic [XLEN-1:0] m_res,
    input logic [4:0]      w_rd,
    input logic            w_we,
    input logic [XLEN-1:0] w_res
  );
    if (m_we && m_rd != 5'd0 && m_rd == rs)
      return m_res;
    else if (w_we && w_rd != 5'd0 && w_rd == rs)
      return w_res;
    else
      return regval;
  endfunction

  assign rs1_fwd = forward(rs1_q, rs1_data_q, exm_rd, exm_regwrite, exm_result,
                           wb_rd, wb_regwrite, wb_result);
  assign rs2_fwd = forward(rs2_q, rs2_data_q, exm_rd, exm_regwrite, exm_result,
                           wb_rd, wb_regwrite, wb_result);
`else
  assign rs1_fwd = rs1_data_q;
  assign rs2_fwd = rs2_data_q;

  // writeback ports and source indices only matter when forwarding is built in
  logic unused_fwd;
  assign unused_fwd = ^{exm_rd, exm_regwrite, exm_result,
                        wb_rd, wb_regwrite, wb_result, rs1_q, rs2_q};
`endif

  always_comb begin
    ex_shamt = 5'd0;
    case (shamt_sel_q)
      SHAMT_IMM: ex_shamt = imm_q[4:0];
      SHAMT_RS2: ex_shamt = rs2_fwd[4:0];
      default:   ex_shamt = 5'd0;
    endcase
  end

  assign ex_a        = a_pc_q  ? pc_q  : rs1_fwd;
  assign ex_b        = b_imm_q ? imm_q : rs2_fwd;
  assign ex_rs2_fwd  = rs2_fwd;
  assign ex_valid    = valid_q;
  assign ex_alufn    = alufn_q;
  assign ex_rd       = rd_q;
  assign ex_regwrite = regwrite_q;
  assign ex_pc       = pc_q;
  assign ex_illegal  = illegal_q;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Testbench for id_ex_alu_stage: table of instruction vectors streamed
// through the stage with a scoreboard of expected EX outputs, followed by
// hand-written stall / flush / reset sequences.
module tb_id_ex_alu_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic [4:0]  exm_rd, wb_rd;
  logic        exm_regwrite, wb_regwrite;
  logic [31:0] exm_result, wb_result;
  logic        ex_valid, ex_regwrite, ex_illegal;
  logic [31:0] ex_a, ex_b, ex_rs2_fwd, ex_pc;
  logic [4:0]  ex_shamt, ex_rd;
  logic [3:0]  ex_alufn;

  always #5 clk = ~clk;

  id_ex_alu_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .exm_rd(exm_rd), .exm_regwrite(exm_regwrite), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_shamt(ex_shamt),
    .ex_alufn(ex_alufn), .ex_rs2_fwd(ex_rs2_fwd), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_pc(ex_pc), .ex_illegal(ex_illegal)
  );

  typedef struct {
    logic        valid;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic [3:0]  alufn;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  typedef struct {
    string       name;
    logic        valid;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic [4:0]  exm_rd;
    logic        exm_rw;
    logic [31:0] exm_res;
    logic [4:0]  wb_rd;
    logic        wb_rw;
    logic [31:0] wb_res;
    exp_t        exp;
  } vec_t;

  localparam int NV = 21;
  vec_t vt[NV];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t bubble();
    exp_t e;
    e.valid = 1'b0; e.a = '0; e.b = '0; e.shamt = '0; e.alufn = '0;
    e.rs2 = '0; e.rd = '0; e.rw = 1'b0; e.pc = '0; e.ill = 1'b0;
    return e;
  endfunction

  function automatic vec_t mkv(string n, logic [6:0] op, logic [2:0] f3, logic f7,
                               logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                               logic [31:0] d1, logic [31:0] d2, logic [31:0] imm,
                               logic [31:0] pc, logic [31:0] ea, logic [31:0] eb,
                               logic [4:0] esh, logic [3:0] efn, logic [31:0] ers2,
                               logic erw, logic eill);
    vec_t v;
    v.name = n; v.valid = 1'b1; v.op = op; v.f3 = f3; v.f7 = f7;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.d1 = d1; v.d2 = d2; v.imm = imm; v.pc = pc;
    v.exm_rd = '0; v.exm_rw = 1'b0; v.exm_res = '0;
    v.wb_rd = '0; v.wb_rw = 1'b0; v.wb_res = '0;
    v.exp.valid = 1'b1; v.exp.a = ea; v.exp.b = eb; v.exp.shamt = esh;
    v.exp.alufn = efn; v.exp.rs2 = ers2; v.exp.rd = rd; v.exp.rw = erw;
    v.exp.pc = pc; v.exp.ill = eill;
    return v;
  endfunction

  task automatic drive_id(input vec_t v);
    id_valid = v.valid; id_opcode = v.op; id_funct3 = v.f3; id_funct7b5 = v.f7;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_rs1_data = v.d1; id_rs2_data = v.d2; id_imm = v.imm; id_pc = v.pc;
  endtask

  task automatic drive_fwd(input vec_t v);
    exm_rd = v.exm_rd; exm_regwrite = v.exm_rw; exm_result = v.exm_res;
    wb_rd = v.wb_rd; wb_regwrite = v.wb_rw; wb_result = v.wb_res;
  endtask

  task automatic clear_fwd();
    exm_rd = '0; exm_regwrite = 1'b0; exm_result = '0;
    wb_rd = '0; wb_regwrite = 1'b0; wb_result = '0;
  endtask

  task automatic cmp(input string tag, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", tag, fld, act, req);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    cmp(tag, "valid",    32'(ex_valid),    32'(e.valid));
    cmp(tag, "a",        ex_a,             e.a);
    cmp(tag, "b",        ex_b,             e.b);
    cmp(tag, "shamt",    32'(ex_shamt),    32'(e.shamt));
    cmp(tag, "alufn",    32'(ex_alufn),    32'(e.alufn));
    cmp(tag, "rs2_fwd",  ex_rs2_fwd,       e.rs2);
    cmp(tag, "rd",       32'(ex_rd),       32'(e.rd));
    cmp(tag, "regwrite", 32'(ex_regwrite), 32'(e.rw));
    cmp(tag, "pc",       ex_pc,            e.pc);
    cmp(tag, "illegal",  32'(ex_illegal),  32'(e.ill));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;

    //            name       op      f3    f7  rs1 rs2 rd  d1            d2            imm           pc
    //            a             b             sh  fn     rs2f          rw ill
    vt[0]  = mkv("add",      7'h33, 3'd0, 0, 1,  2,  3,  32'd5,        32'd7,        32'd0,        32'h40,
                 32'd5,        32'd7,        0,  4'h0, 32'd7,        1, 0);
    vt[1]  = mkv("srai",     7'h13, 3'd5, 1, 1,  3,  4,  32'h80000010, 32'h11,       32'h403,      32'h44,
                 32'h80000010, 32'h403,      3,  4'hA, 32'h11,       1, 0);
    vt[2]  = mkv("sub",      7'h33, 3'd0, 1, 6,  7,  5,  32'd100,      32'd30,       32'd0,        32'h48,
                 32'd100,      32'd30,       0,  4'h1, 32'd30,       1, 0);
    vt[3]  = mkv("sltu",     7'h33, 3'd3, 0, 9,  10, 8,  32'd1,        32'd2,        32'd0,        32'h4C,
                 32'd1,        32'd2,        0,  4'hF, 32'd2,        1, 0);
    vt[4]  = mkv("sll",      7'h33, 3'd1, 0, 12, 13, 11, 32'hF0,       32'h25,       32'd0,        32'h50,
                 32'hF0,       32'h25,       5,  4'h9, 32'h25,       1, 0);
    vt[5]  = mkv("fwd_both", 7'h33, 3'd0, 0, 1,  2,  14, 32'h11,       32'h22,       32'd0,        32'h54,
                 32'h11,       32'h22,       0,  4'h0, 32'h22,       1, 0);
    vt[6]  = mkv("fwd_rd0",  7'h33, 3'd0, 0, 0,  2,  17, 32'h33,       32'h44,       32'd0,        32'h58,
                 32'h33,       32'h44,       0,  4'h0, 32'h44,       1, 0);
    vt[7]  = mkv("fwd_wb",   7'h33, 3'd6, 0, 3,  2,  18, 32'h5,        32'h66,       32'd0,        32'h5C,
                 32'h5,        32'h66,       0,  4'h4, 32'h66,       1, 0);
    vt[8]  = mkv("auipc",    7'h17, 3'd0, 0, 0,  0,  15, 32'd0,        32'd0,        32'h1000,     32'h100,
                 32'h100,      32'h1000,     0,  4'h0, 32'd0,        1, 0);
    vt[9]  = mkv("opc_7f",   7'h7F, 3'd0, 0, 0,  0,  16, 32'd0,        32'd0,        32'd0,        32'h60,
                 32'd0,        32'd0,        0,  4'h0, 32'd0,        0, 1);
    vt[10] = mkv("beq",      7'h63, 3'd0, 0, 4,  5,  5,  32'd9,        32'd9,        32'h20,       32'h64,
                 32'd9,        32'd9,        0,  4'h1, 32'd9,        0, 0);
    vt[11] = mkv("bltu",     7'h63, 3'd6, 0, 4,  5,  0,  32'd1,        32'd3,        32'h8,        32'h68,
                 32'd1,        32'd3,        0,  4'hF, 32'd3,        0, 0);
    vt[12] = mkv("lui",      7'h37, 3'd2, 0, 0,  0,  19, 32'd0,        32'd0,        32'h12345000, 32'h6C,
                 32'd0,        32'h12345000, 0,  4'h3, 32'd0,        1, 0);
    vt[13] = mkv("sw",       7'h23, 3'd2, 0, 8,  9,  4,  32'h1000,     32'hDEADBEEF, 32'h10,       32'h70,
                 32'h1000,     32'h10,       0,  4'h0, 32'hDEADBEEF, 0, 0);
    vt[14] = mkv("invalid",  7'h33, 3'd0, 0, 1,  2,  3,  32'd5,        32'd7,        32'd0,        32'h74,
                 32'd0,        32'd0,        0,  4'h0, 32'd0,        0, 0);
    vt[15] = mkv("xor_f7",   7'h33, 3'd4, 1, 0,  0,  20, 32'd0,        32'd0,        32'd0,        32'h78,
                 32'd0,        32'd0,        0,  4'h0, 32'd0,        0, 1);
    vt[16] = mkv("jal",      7'h6F, 3'd0, 0, 0,  0,  1,  32'd0,        32'd0,        32'h10,       32'h200,
                 32'h200,      32'h10,       0,  4'h0, 32'd0,        1, 0);
    vt[17] = mkv("add_x0",   7'h33, 3'd0, 0, 1,  2,  0,  32'd3,        32'd4,        32'd0,        32'h7C,
                 32'd3,        32'd4,        0,  4'h0, 32'd4,        0, 0);
    vt[18] = mkv("sra",      7'h33, 3'd5, 1, 1,  2,  21, 32'h80000000, 32'h24,       32'd0,        32'h80,
                 32'h80000000, 32'h24,       4,  4'hA, 32'h24,       1, 0);
    vt[19] = mkv("lw",       7'h03, 3'd2, 0, 1,  0,  22, 32'h2000,     32'd0,        32'hFFFFFFFC, 32'h84,
                 32'h2000,     32'hFFFFFFFC, 0,  4'h0, 32'd0,        1, 0);
    vt[20] = mkv("slti",     7'h13, 3'd2, 1, 1,  5,  23, 32'd7,        32'd0,        32'hFFFFFC05, 32'h88,
                 32'd7,        32'hFFFFFC05, 0,  4'hD, 32'd0,        1, 0);

    // EX-cycle writeback traffic for the forwarding vectors
    vt[5].exm_rd = 5'd1; vt[5].exm_rw = 1'b1; vt[5].exm_res = 32'hAA;
    vt[5].wb_rd  = 5'd1; vt[5].wb_rw  = 1'b1; vt[5].wb_res  = 32'hBB;
    vt[6].exm_rd = 5'd0; vt[6].exm_rw = 1'b1; vt[6].exm_res = 32'hAA;
    vt[6].wb_rd  = 5'd0; vt[6].wb_rw  = 1'b1; vt[6].wb_res  = 32'hBB;
    vt[7].exm_rd = 5'd2; vt[7].exm_rw = 1'b0; vt[7].exm_res = 32'hAA;
    vt[7].wb_rd  = 5'd2; vt[7].wb_rw  = 1'b1; vt[7].wb_res  = 32'hBB;
`ifdef FORWARDING_EN
    vt[5].exp.a   = 32'hAA;
    vt[7].exp.b   = 32'hBB;
    vt[7].exp.rs2 = 32'hBB;
`endif
    vt[14].valid = 1'b0;
    vt[14].exp   = bubble();

    // reset beats a valid instruction at the input
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    clear_fwd();
    drive_id(vt[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb.push_back(bubble());
    check_out("reset");
    rst = 1'b0;

    // table stream: EX result of vector i is checked while vector i+1 is driven
    for (int i = 0; i <= NV; i++) begin
      if (i > 0) begin
        @(negedge clk);
        check_out(vt[i-1].name);
      end
      if (i < NV) begin
        drive_id(vt[i]);
        sb.push_back(vt[i].exp);
      end else begin
        id_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i < NV) drive_fwd(vt[i]);
      else clear_fwd();
    end
    @(negedge clk);

    // stall: ADD held for 3 cycles while other slots sit at the input
    drive_id(vt[0]);
    sb.push_back(vt[0].exp);
    @(posedge clk); #1; clear_fwd();
    @(negedge clk); check_out("stall_load");
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_id(k == 1 ? vt[14] : vt[2]);
      e = vt[0].exp;
`ifdef FORWARDING_EN
      if (k == 2) e.a = 32'h99;
`endif
      sb.push_back(e);
      @(posedge clk); #1;
      if (k == 2) begin
        exm_rd = 5'd1; exm_regwrite = 1'b1; exm_result = 32'h99;
      end
      @(negedge clk); check_out($sformatf("stall_hold%0d", k));
    end
    clear_fwd();

    // stall and flush together: flush wins
    flush = 1'b1;
    sb.push_back(bubble());
    @(posedge clk); #1;
    @(negedge clk); check_out("stall_flush");
    flush = 1'b0; stall = 1'b0;

    // flush alone discards a valid slot
    drive_id(vt[3]);
    sb.push_back(vt[3].exp);
    @(posedge clk); #1;
    @(negedge clk); check_out("pre_flush");
    flush = 1'b1;
    sb.push_back(bubble());
    @(posedge clk); #1;
    @(negedge clk); check_out("flush");
    flush = 1'b0;

    // reset while stalled drops the held instruction
    drive_id(vt[2]);
    sb.push_back(vt[2].exp);
    @(posedge clk); #1;
    @(negedge clk); check_out("pre_rst_stall");
    stall = 1'b1;
    @(posedge clk); #1;
    sb.push_back(vt[2].exp);
    @(negedge clk); check_out("stalled");
    rst = 1'b1;
    sb.push_back(bubble());
    @(posedge clk); #1;
    @(negedge clk); check_out("rst_mid_stall");
    rst = 1'b0; stall = 1'b0; id_valid = 1'b0;
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
